// File: rtl/ntt_pkg.sv
// ntt_pkg: definitions shared by the NTT stream bridge and its buffer.
//   state_t   - bridge FSM states (IDLE/LOAD/RUN/DRAIN)
//   calc_aw() - wrapper address width for a given LOGN
//   calc_n()  - polynomial length N = 1 << LOGN
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int DEF_LOGQ = 64;
  localparam int DEF_LOGN = 4;
  localparam int DEF_N    = 1 << DEF_LOGN;

  // The wrapper always exposes at least a 10-bit address bus.
  function automatic int calc_aw(input int logn);
    return ((logn < 9) ? 9 : logn) + 1;
  endfunction

  function automatic int calc_n(input int logn);
    return 1 << logn;
  endfunction

endpackage

// File: rtl/ntt_bridge_buf.sv
// ntt_bridge_buf: N x W simple dual-port RAM for the stream bridge.
//   clk, rst        - clock, synchronous active-high reset (read register only)
//   we/waddr/wdata  - write port
//   re/raddr/rdata  - read port, one-cycle registered; rdata holds when re=0
// A read and a write to the same address in one cycle return the old data.
module ntt_bridge_buf
  import ntt_pkg::*;
#(
  parameter int W    = DEF_LOGQ,
  parameter int LOGN = DEF_LOGN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [LOGN-1:0] waddr,
  input  logic [W-1:0]    wdata,
  input  logic            re,
  input  logic [LOGN-1:0] raddr,
  output logic [W-1:0]    rdata
);

  localparam int N = calc_n(LOGN);

  logic [W-1:0] mem [0:N-1];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ntt_stream_bridge.sv
// ntt_stream_bridge: streaming front/back end for ntt_memory_wrapper.
// Loads N coefficients from the s_* stream into a local buffer, runs the
// wrapper against that buffer (serving its reads, capturing its write-backs),
// then streams the N results out on m_* in natural index order.
//   clk, rst              - clock, synchronous active-high reset
//   mode_intt, q_in       - transform mode / modulus, taken on first input beat
//   s_valid/s_ready/s_data - input stream
//   m_valid/m_ready/m_data - output stream
//   busy                  - high whenever the FSM is not IDLE
//   ntt_start/ntt_intt/ntt_q                   - run request and parameters
//   ntt_read_address/ntt_data_in               - wrapper read, 1-cycle latency
//   ntt_wea/ntt_write_address/ntt_data_out     - wrapper write-back
//   ntt_finish            - wrapper done
//   dbg_state             - current FSM state
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; a source holds valid/data stable until that edge.
// Build option: define NTT_BRIDGE_INRED_EN to reduce each input beat once
// modulo q before it is stored.
module ntt_stream_bridge
  import ntt_pkg::*;
#(
  parameter int LOGQ = DEF_LOGQ,
  parameter int LOGN = DEF_LOGN,
  parameter int AW   = calc_aw(LOGN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mode_intt,
  input  logic [LOGQ-1:0] q_in,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [LOGQ-1:0] s_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [LOGQ-1:0] m_data,
  output logic            busy,
  output logic            ntt_start,
  output logic            ntt_intt,
  output logic [LOGQ-1:0] ntt_q,
  input  logic [AW-1:0]   ntt_read_address,
  output logic [LOGQ-1:0] ntt_data_in,
  input  logic            ntt_wea,
  input  logic [AW-1:0]   ntt_write_address,
  input  logic [LOGQ-1:0] ntt_data_out,
  input  logic            ntt_finish,
  output state_t          dbg_state
);

  localparam int N  = calc_n(LOGN);
  localparam int CW = LOGN + 1;

  state_t          state;
  logic [CW-1:0]   cnt;        // load index in LOAD, prefetch index in DRAIN
  logic            s_fire;
  logic            m_fire;
  logic            drain_done; // every index has been fetched
  logic [LOGQ-1:0] load_data;

  logic            buf_we;
  logic [LOGN-1:0] buf_waddr;
  logic [LOGQ-1:0] buf_wdata;
  logic            buf_re;
  logic [LOGN-1:0] buf_raddr;
  logic [LOGQ-1:0] buf_rdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ntt_read_address[AW-1:LOGN], ntt_write_address[AW-1:LOGN]};

  assign s_fire     = s_valid & s_ready;
  assign m_fire     = m_valid & m_ready;
  assign drain_done = (cnt == CW'(N));
  assign busy       = (state != ST_IDLE);
  assign dbg_state  = state;

`ifdef NTT_BRIDGE_INRED_EN
  // The first beat arrives before ntt_q is latched, so it uses q_in.
  logic [LOGQ-1:0] red_q;
  assign red_q     = (state == ST_IDLE) ? q_in : ntt_q;
  assign load_data = (s_data >= red_q) ? s_data - red_q : s_data;
`else
  assign load_data = s_data;
`endif

  // The buffer read register is both the wrapper's read data and the output
  // prefetch register; in DRAIN it only reloads when empty or being consumed.
  always_comb begin
    buf_we    = 1'b0;
    buf_waddr = '0;
    buf_wdata = load_data;
    buf_re    = 1'b0;
    buf_raddr = '0;
    case (state)
      ST_IDLE: begin
        buf_we    = s_fire;
        buf_waddr = '0;
      end
      ST_LOAD: begin
        buf_we    = s_fire;
        buf_waddr = cnt[LOGN-1:0];
      end
      ST_RUN: begin
        buf_we    = ntt_wea;
        buf_waddr = ntt_write_address[LOGN-1:0];
        buf_wdata = ntt_data_out;
        buf_re    = 1'b1;
        buf_raddr = ntt_read_address[LOGN-1:0];
      end
      ST_DRAIN: begin
        buf_re    = (!m_valid || m_ready) && !drain_done;
        buf_raddr = cnt[LOGN-1:0];
      end
      default: ;
    endcase
  end

  ntt_bridge_buf #(.W(LOGQ), .LOGN(LOGN)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (buf_wdata),
    .re    (buf_re),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  assign m_data      = buf_rdata;
  assign ntt_data_in = buf_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      s_ready   <= 1'b0;
      m_valid   <= 1'b0;
      ntt_start <= 1'b0;
      ntt_intt  <= 1'b0;
      ntt_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          s_ready   <= 1'b1;
          m_valid   <= 1'b0;
          ntt_start <= 1'b0;
          if (s_fire) begin
            ntt_intt <= mode_intt;
            ntt_q    <= q_in;
            cnt      <= CW'(1);
            state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (s_fire) begin
            cnt <= cnt + CW'(1);
            if (cnt == CW'(N - 1)) begin
              s_ready   <= 1'b0;
              ntt_start <= 1'b1;
              state     <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (ntt_finish) begin
            ntt_start <= 1'b0;
            cnt       <= '0;
            state     <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (m_fire && drain_done) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= ST_IDLE;
          end else if (buf_re) begin
            cnt     <= cnt + CW'(1);
            m_valid <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_stream_bridge.sv
// tb_ntt_stream_bridge: self-checking bench for ntt_stream_bridge.
// A small behavioural wrapper visits every buffer address once in random
// order, checks the read data, and writes back a simple modular function of
// it. Expected outputs are that function applied to the stored input values.
module tb_ntt_stream_bridge;
  import ntt_pkg::*;

  localparam int LOGQ = 64;
  localparam int LOGN = 4;
  localparam int N    = 16;
  localparam int AW   = calc_aw(LOGN);
  localparam logic [63:0] QG = 64'hFFFF_FFFF_0000_0001;
  localparam logic [AW-1:0] HI = AW'(1) << (AW - 1);
`ifdef NTT_BRIDGE_INRED_EN
  localparam bit INRED = 1'b1;
`else
  localparam bit INRED = 1'b0;
`endif

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            mode_intt = 1'b0;
  logic [LOGQ-1:0] q_in = '0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [LOGQ-1:0] s_data = '0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [LOGQ-1:0] m_data;
  logic            busy;
  logic            ntt_start;
  logic            ntt_intt;
  logic [LOGQ-1:0] ntt_q;
  logic [AW-1:0]   ntt_read_address = '0;
  logic [LOGQ-1:0] ntt_data_in;
  logic            ntt_wea = 1'b0;
  logic [AW-1:0]   ntt_write_address = '0;
  logic [LOGQ-1:0] ntt_data_out = '0;
  logic            ntt_finish = 1'b0;
  state_t          dbg_state;

  ntt_stream_bridge #(.LOGQ(LOGQ), .LOGN(LOGN), .AW(AW)) dut (
    .clk               (clk),
    .rst               (rst),
    .mode_intt         (mode_intt),
    .q_in              (q_in),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_data            (s_data),
    .m_valid           (m_valid),
    .m_ready           (m_ready),
    .m_data            (m_data),
    .busy              (busy),
    .ntt_start         (ntt_start),
    .ntt_intt          (ntt_intt),
    .ntt_q             (ntt_q),
    .ntt_read_address  (ntt_read_address),
    .ntt_data_in       (ntt_data_in),
    .ntt_wea           (ntt_wea),
    .ntt_write_address (ntt_write_address),
    .ntt_data_out      (ntt_data_out),
    .ntt_finish        (ntt_finish),
    .dbg_state         (dbg_state)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [LOGQ-1:0] exp_q[$];
  logic [LOGQ-1:0] din[N];
  logic [LOGQ-1:0] stored[N];

  typedef struct {
    logic        mode;
    logic [63:0] q;
    int          gap_at;
    int          gap_len;
    logic        bp;
    logic        qp5;
    int          exp_load_cycles;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] stored_val(input logic [63:0] d, input logic [63:0] q);
    return (INRED && d >= q) ? d - q : d;
  endfunction

  // The behavioural wrapper's transform: forward 3x+7, inverse xor-mask, both mod q.
  function automatic logic [63:0] wrap_f(input logic mode, input logic [63:0] x,
                                          input logic [63:0] q);
    logic [127:0] t;
    if (!mode) t = ({64'd0, x} * 128'd3 + 128'd7) % {64'd0, q};
    else       t = {64'd0, x ^ 64'h5A5A_5A5A_0F0F_0F0F} % {64'd0, q};
    return t[63:0];
  endfunction

  task automatic load_poly(input logic mode, input logic [63:0] q, input int gap_at,
                           input int gap_len, input logic qp5, input int exp_cycles);
    int cyc;
    int guard;
    for (int i = 0; i < N; i++) begin
      din[i]    = {$urandom(), $urandom()};
      stored[i] = stored_val(din[i], q);
    end
    if (qp5) begin
      din[0]    = q + 64'd5;
      stored[0] = stored_val(din[0], q);
    end
    guard = 0;
    while (!s_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk("load_ready", s_ready, 1);
    mode_intt = mode;
    q_in      = q;
    // Wrapper-side noise that must be ignored outside RUN.
    ntt_wea = 1'b1; ntt_write_address = AW'(3); ntt_data_out = '1; ntt_finish = 1'b1;
    cyc = 0;
    for (int i = 0; i < N; i++) begin
      if (i == gap_at) begin
        s_valid = 1'b0;
        for (int g = 0; g < gap_len; g++) begin
          tick();
          cyc++;
        end
      end
      s_valid = 1'b1;
      s_data  = din[i];
      chk("beat_ready", s_ready, 1);
      tick();
      cyc++;
      if (i == 0) begin
        mode_intt = ~mode;
        q_in      = ~q;
      end
    end
    s_valid = 1'b0;
    ntt_wea = 1'b0; ntt_write_address = '0; ntt_data_out = '0; ntt_finish = 1'b0;
    chk("load_cycles", cyc, exp_cycles);
    chk("start_lat", ntt_start, 1);
    chk("s_ready_run", s_ready, 0);
    chk("busy_run", busy, 1);
  endtask

  task automatic run_wrapper(input logic mode, input logic [63:0] q, input logic qp5);
    logic [3:0] perm[N];
    logic [3:0] tmp;
    logic [63:0] y;
    int j;
    for (int i = 0; i < N; i++) perm[i] = 4'(i);
    for (int i = N - 1; i >= 2; i--) begin
      j = $urandom_range(i, 1);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    m_ready = 1'b0;
    chk("ntt_intt", ntt_intt, mode);
    chk("ntt_q", ntt_q, q);
    for (int k = 0; k < N; k++) begin
      ntt_read_address = HI | AW'(perm[k]);
      tick();
      chk("rd_data", ntt_data_in, stored[perm[k]]);
      if (qp5 && k == 0) chk("inred_first_read", ntt_data_in, INRED ? 64'd5 : q + 64'd5);
      chk("start_hold", ntt_start, 1);
      y = wrap_f(ntt_intt, ntt_data_in, ntt_q);
      ntt_wea           = 1'b1;
      ntt_write_address = HI | AW'(perm[k]);
      ntt_data_out      = y;
      ntt_finish        = (k == N - 1);
      tick();
      chk("rd_collide_old", ntt_data_in, stored[perm[k]]);
      ntt_wea    = 1'b0;
      ntt_finish = 1'b0;
    end
    chk("start_drop", ntt_start, 0);
    chk("m_valid_early", m_valid, 0);
    chk("state_drain", dbg_state, ST_DRAIN);
    tick();
    chk("first_out_lat", m_valid, 1);
  endtask

  task automatic drain(input logic bp);
    int cyc;
    logic stalled;
    logic [63:0] held;
    logic [63:0] e;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (exp_q.size() > 0 && cyc < 200) begin
      m_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (stalled) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, held);
      end
      if (m_valid && m_ready) begin
        e = exp_q.pop_front();
        chk("out_data", m_data, e);
        stalled = 1'b0;
      end else begin
        stalled = m_valid;
        held    = m_data;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    if (!bp) chk("drain_cycles", cyc, N);
    chk("done_m_valid", m_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_s_ready", s_ready, 1);
  endtask

  task automatic expect_results(input logic mode, input logic [63:0] q);
    for (int i = 0; i < N; i++) exp_q.push_back(wrap_f(mode, stored_val(din[i], q), q));
  endtask

  task automatic run_txn(input vec_t v);
    load_poly(v.mode, v.q, v.gap_at, v.gap_len, v.qp5, v.exp_load_cycles);
    run_wrapper(v.mode, v.q, v.qp5);
    expect_results(v.mode, v.q);
    drain(v.bp);
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    vec_t v;
    vecs[0] = '{mode: 1'b0, q: QG, gap_at: -1, gap_len: 0, bp: 1'b0, qp5: 1'b0, exp_load_cycles: 16};
    vecs[1] = '{mode: 1'b1, q: QG, gap_at: -1, gap_len: 0, bp: 1'b0, qp5: 1'b0, exp_load_cycles: 16};
    vecs[2] = '{mode: 1'b0, q: QG, gap_at: -1, gap_len: 0, bp: 1'b1, qp5: 1'b0, exp_load_cycles: 16};
    vecs[3] = '{mode: 1'b0, q: QG, gap_at: 6,  gap_len: 3, bp: 1'b0, qp5: 1'b0, exp_load_cycles: 19};
    vecs[4] = '{mode: 1'b1, q: QG, gap_at: -1, gap_len: 0, bp: 1'b0, qp5: 1'b1, exp_load_cycles: 16};
    vecs[5] = '{mode: 1'b0, q: 64'd97, gap_at: 10, gap_len: 2, bp: 1'b1, qp5: 1'b0, exp_load_cycles: 18};

    rst = 1'b1;
    repeat (3) tick();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", ntt_start, 0);
    chk("rst_intt", ntt_intt, 0);
    chk("rst_q", ntt_q, 0);
    chk("rst_data_in", ntt_data_in, 0);
    rst = 1'b0;
    tick();
    chk("idle_s_ready", s_ready, 1);

    for (int t = 0; t < 6; t++) run_txn(vecs[t]);

    // Reset in the tenth RUN cycle aborts; a fresh load must then work.
    load_poly(1'b0, QG, -1, 0, 1'b0, 16);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_start", ntt_start, 0);
    chk("abort_busy", busy, 0);
    chk("abort_m_valid", m_valid, 0);
    tick();
    chk("abort_s_ready", s_ready, 1);
    run_txn(vecs[1]);

    for (int t = 0; t < 4; t++) begin
      v.mode    = 1'($urandom_range(1, 0));
      v.q       = QG;
      v.gap_at  = $urandom_range(15, 1);
      v.gap_len = $urandom_range(3, 0);
      v.bp      = 1'($urandom_range(1, 0));
      v.qp5     = 1'b0;
      v.exp_load_cycles = 16 + v.gap_len;
      run_txn(v);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
